// File: rtl/bitstuff_codec_if.sv
// rtl/bitstuff_codec_if.sv - control and serial handshake bundle for bitstuff_codec
interface bitstuff_codec_if;
    logic start;
    logic mode;
    logic endb;
    logic in_bit;
    logic in_valid;
    logic in_ready;
    logic out_bit;
    logic out_valid;
    logic start_nrzi;
    logic done;
    logic active;
    logic stuff_err;

    modport master (
        output start, mode, endb, in_bit, in_valid,
        input  in_ready, out_bit, out_valid, start_nrzi, done, active, stuff_err
    );

    modport slave (
        input  start, mode, endb, in_bit, in_valid,
        output in_ready, out_bit, out_valid, start_nrzi, done, active, stuff_err
    );
endinterface

// File: rtl/bitstuff_codec.sv
// rtl/bitstuff_codec.sv - USB-style bit stuffer (TX) / unstuffer (RX) with header bypass
module bitstuff_codec #(
    parameter int RUN_LEN     = 6,
    parameter int BYPASS_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bitstuff_codec_if.slave  bus
);
    localparam int OW = $clog2(RUN_LEN + 1);
    localparam int BW = (BYPASS_BITS > 0) ? $clog2(BYPASS_BITS + 1) : 1;
    localparam logic [OW-1:0] RUN_MAX  = OW'(RUN_LEN);
    localparam logic [BW-1:0] BYP_LAST = BW'(BYPASS_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYPASS,
        S_RUN,
        S_INSERT
    } state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [OW-1:0]   ones_q, ones_d;
    logic [BW-1:0]   byp_q, byp_d;
    logic            stuff_err_q, stuff_err_d;

    logic [OW-1:0]   ones_inc;
    logic [BW-1:0]   byp_inc;
    logic            in_ready_c;
    logic            out_bit_c;
    logic            out_valid_c;
    logic            start_nrzi_c;
    logic            done_c;

    assign ones_inc = ones_q + OW'(1);
    assign byp_inc  = byp_q + BW'(1);

    // State and counter registers; reset drops any pending insertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            ones_q      <= '0;
            byp_q       <= '0;
            stuff_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ones_q      <= ones_d;
            byp_q       <= byp_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    // Next-state, counter updates and the zero-latency serial datapath
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        ones_d       = ones_q;
        byp_d        = byp_q;
        stuff_err_d  = stuff_err_q;
        in_ready_c   = 1'b0;
        out_bit_c    = 1'b0;
        out_valid_c  = 1'b0;
        start_nrzi_c = 1'b0;
        done_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // start wins over endb here; gated by rst_n so nothing leaks during reset
                if (bus.start && rst_n) begin
                    start_nrzi_c = 1'b1;
                    mode_d       = bus.mode;
                    stuff_err_d  = 1'b0;
                    ones_d       = '0;
                    byp_d        = '0;
                    state_d      = (BYPASS_BITS == 0) ? S_RUN : S_BYPASS;
                end
            end

            S_BYPASS: begin
                if (bus.endb) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        out_valid_c = 1'b1;
                        out_bit_c   = bus.in_bit;
                        byp_d       = byp_inc;
                        if (byp_inc == BYP_LAST) begin
                            state_d = S_RUN;
                        end
                    end
                end
            end

            S_RUN: begin
                if (bus.endb) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        if (!mode_q || (ones_q != RUN_MAX)) begin
                            out_valid_c = 1'b1;
                            out_bit_c   = bus.in_bit;
                            if (bus.in_bit) begin
                                ones_d = ones_inc;
                                if (!mode_q && (ones_inc == RUN_MAX)) begin
                                    state_d = S_INSERT;
                                end
                            end else begin
                                ones_d = '0;
                            end
                        end else if (!bus.in_bit) begin
                            // RX: this is the stuffed zero, swallow it
                            ones_d = '0;
                        end else begin
                            stuff_err_d = 1'b1;
                            done_c      = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                end
            end

            S_INSERT: begin
                // endb is deliberately not looked at: the stuffed zero always goes out first
                out_valid_c = 1'b1;
                out_bit_c   = 1'b0;
                ones_d      = '0;
                state_d     = S_RUN;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_bit    = out_bit_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.start_nrzi = start_nrzi_c;
    assign bus.done       = done_c;
    assign bus.active     = (state_q != S_IDLE);
    assign bus.stuff_err  = stuff_err_q;
endmodule

// File: tb/tb_bitstuff_codec.sv
// tb/tb_bitstuff_codec.sv - self-checking bench for bitstuff_codec
module tb_bitstuff_codec;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bitstuff_codec_if bus0 ();
    bitstuff_codec_if bus1 ();

    bitstuff_codec #(.RUN_LEN(6), .BYPASS_BITS(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    bitstuff_codec #(.RUN_LEN(3), .BYPASS_BITS(0))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int   cur = 0;
    logic start_v = 1'b0, mode_v = 1'b0, endb_v = 1'b0, bit_v = 1'b0, valid_v = 1'b0;

    assign bus0.start    = (cur == 0) ? start_v : 1'b0;
    assign bus0.mode     = (cur == 0) ? mode_v  : 1'b0;
    assign bus0.endb     = (cur == 0) ? endb_v  : 1'b0;
    assign bus0.in_bit   = (cur == 0) ? bit_v   : 1'b0;
    assign bus0.in_valid = (cur == 0) ? valid_v : 1'b0;
    assign bus1.start    = (cur == 1) ? start_v : 1'b0;
    assign bus1.mode     = (cur == 1) ? mode_v  : 1'b0;
    assign bus1.endb     = (cur == 1) ? endb_v  : 1'b0;
    assign bus1.in_bit   = (cur == 1) ? bit_v   : 1'b0;
    assign bus1.in_valid = (cur == 1) ? valid_v : 1'b0;

    logic o_ready, o_bit, o_valid, o_start_nrzi, o_done, o_active, o_stuff_err;
    assign o_ready      = (cur == 1) ? bus1.in_ready   : bus0.in_ready;
    assign o_bit        = (cur == 1) ? bus1.out_bit    : bus0.out_bit;
    assign o_valid      = (cur == 1) ? bus1.out_valid  : bus0.out_valid;
    assign o_start_nrzi = (cur == 1) ? bus1.start_nrzi : bus0.start_nrzi;
    assign o_done       = (cur == 1) ? bus1.done       : bus0.done;
    assign o_active     = (cur == 1) ? bus1.active     : bus0.active;
    assign o_stuff_err  = (cur == 1) ? bus1.stuff_err  : bus0.stuff_err;

    int total = 0;
    int bad   = 0;
    bit expq[$];
    logic [15:0] hdr_pat = 16'hA5C3;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: expected output stream of a whole packet from the stuffing rules
    task automatic model(input bit m, input int byp, input int run, input bit bits[$],
                         output bit q[$], output bit err, output int err_pos);
        int cnt;
        cnt = 0; err = 1'b0; err_pos = 0; q = {};
        for (int i = 0; i < bits.size(); i++) begin
            if (i < byp) begin
                q.push_back(bits[i]);
            end else if (!m) begin
                q.push_back(bits[i]);
                cnt = bits[i] ? cnt + 1 : 0;
                if (cnt == run) begin
                    q.push_back(1'b0);
                    cnt = 0;
                end
            end else if (cnt == run) begin
                if (bits[i]) begin
                    err = 1'b1;
                    err_pos = i + 1;
                    break;
                end
                cnt = 0;
            end else begin
                q.push_back(bits[i]);
                cnt = bits[i] ? cnt + 1 : 0;
            end
        end
    endtask

    // Every valid output bit must be the next one the model predicts; idle bits read 0
    always @(negedge clk) begin
        if (o_valid) begin
            if (expq.size() == 0) chk("out_extra", 1, 0);
            else                  chk("out_bit", o_bit, expq.pop_front());
        end else begin
            chk("out_bit_idle", o_bit, 0);
        end
    end

    task automatic send(input bit m, input bit bits[$], input bit toggle, input bit no_end,
                        output int done_cyc, output int stall, output int drop);
        bit q[$];
        bit err;
        int err_pos, n, idx, cyc;
        bit got_done;
        model(m, (cur == 1) ? 0 : 16, (cur == 1) ? 3 : 6, bits, q, err, err_pos);
        expq = q;
        n = bits.size(); idx = 0; cyc = 0; stall = 0; drop = 0; done_cyc = 0; got_done = 1'b0;
        @(posedge clk); #1;
        start_v = 1'b1; mode_v = m; endb_v = 1'b0; valid_v = 1'b0;
        @(negedge clk);
        chk("start_nrzi", o_start_nrzi, 1);
        chk("active_idle", o_active, 0);
        while (cyc < 300) begin
            @(posedge clk); #1;
            start_v = 1'b0; mode_v = ~m;
            if (idx < n) begin
                bit_v = bits[idx]; endb_v = 1'b0;
                valid_v = toggle ? ((cyc % 2) == 0) : 1'b1;
            end else begin
                bit_v = 1'b0; valid_v = 1'b0; endb_v = 1'b1;
            end
            @(negedge clk);
            cyc++;
            chk("active_busy", o_active, 1);
            if (cyc == 1) chk("stuff_err_clear", o_stuff_err, 0);
            if (idx < n && !o_ready) stall++;
            if (valid_v && o_ready) begin
                if (!o_valid) drop++;
                idx++;
            end
            if (o_done) begin
                done_cyc = cyc; got_done = 1'b1;
                break;
            end
            if (no_end && idx == n) break;
        end
        if (!no_end) begin
            chk("done_seen", got_done, 1);
            if (!toggle) chk("done_cycle", done_cyc, err ? err_pos : ((m ? n : q.size()) + 1));
            @(posedge clk); #1;
            endb_v = 1'b0; valid_v = 1'b0;
            @(negedge clk);
            chk("done_pulse", o_done, 0);
            chk("active_after", o_active, 0);
            chk("stuff_err", o_stuff_err, err);
            chk("out_missing", expq.size(), 0);
        end
    endtask

    initial begin
        bit bits[$];
        bit q[$];
        bit err;
        int ep, dc, st, dr;

        #2 rst_n = 1'b0;
        start_v = 1'b1; valid_v = 1'b1; bit_v = 1'b1;
        #1;
        chk("rst_in_ready", o_ready, 0);   chk("rst_out_bit", o_bit, 0);
        chk("rst_out_valid", o_valid, 0);  chk("rst_start_nrzi", o_start_nrzi, 0);
        chk("rst_done", o_done, 0);        chk("rst_active", o_active, 0);
        chk("rst_stuff_err", o_stuff_err, 0);
        start_v = 1'b0; valid_v = 1'b0; bit_v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // TX defaults: 16 header ones, 8 payload ones
        cur = 0; bits = {};
        for (int i = 0; i < 24; i++) bits.push_back(1'b1);
        model(1'b0, 16, 6, bits, q, err, ep);
        chk("pin_t1_len", q.size(), 25);
        chk("pin_t1_stuff", q[22], 0);
        send(1'b0, bits, 1'b0, 1'b0, dc, st, dr);
        chk("t1_stall", st, 1);

        // TX RUN_LEN=3 no header: endb lands in the INSERT cycle
        cur = 1; bits = {1'b1, 1'b1, 1'b1};
        model(1'b0, 0, 3, bits, q, err, ep);
        chk("pin_t2_len", q.size(), 4);
        chk("pin_t2_stuff", q[3], 0);
        send(1'b0, bits, 1'b0, 1'b0, dc, st, dr);
        chk("t2_done_cyc", dc, 5);

        // RX defaults: header, 1x6, stuffed 0, 1, 0
        cur = 0; bits = {};
        for (int i = 0; i < 16; i++) bits.push_back(hdr_pat[15-i]);
        for (int i = 0; i < 6; i++) bits.push_back(1'b1);
        bits.push_back(1'b0); bits.push_back(1'b1); bits.push_back(1'b0);
        model(1'b1, 16, 6, bits, q, err, ep);
        chk("pin_t3_len", q.size(), 24);
        chk("pin_t3_err", err, 0);
        send(1'b1, bits, 1'b0, 1'b0, dc, st, dr);
        chk("t3_drop", dr, 1);

        // RX violation: header, 1x7
        bits = {};
        for (int i = 0; i < 16; i++) bits.push_back(hdr_pat[15-i]);
        for (int i = 0; i < 7; i++) bits.push_back(1'b1);
        model(1'b1, 16, 6, bits, q, err, ep);
        chk("pin_t4_err", err, 1);
        chk("pin_t4_pos", ep, 23);
        send(1'b1, bits, 1'b0, 1'b0, dc, st, dr);
        chk("t4_done_cyc", dc, 23);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_err_held", o_stuff_err, 1);
        chk("t4_idle", o_active, 0);

        // TX with in_valid toggling: idle cycles must not clear the run
        bits = {};
        for (int i = 0; i < 16; i++) bits.push_back(hdr_pat[15-i]);
        for (int i = 0; i < 6; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
        model(1'b0, 16, 6, bits, q, err, ep);
        chk("pin_t5_len", q.size(), 24);
        chk("pin_t5_stuff", q[22], 0);
        send(1'b0, bits, 1'b1, 1'b0, dc, st, dr);
        chk("t5_stall", st, 1);

        // Reset while in INSERT, then a clean packet
        bits = {};
        for (int i = 0; i < 16; i++) bits.push_back(hdr_pat[15-i]);
        for (int i = 0; i < 6; i++) bits.push_back(1'b1);
        send(1'b0, bits, 1'b0, 1'b1, dc, st, dr);
        @(posedge clk); #1 valid_v = 1'b0;
        @(negedge clk);
        chk("t6_insert_ready", o_ready, 0);
        chk("t6_insert_valid", o_valid, 1);
        #2 rst_n = 1'b0;
        start_v = 1'b1; valid_v = 1'b1; bit_v = 1'b1;
        #1;
        chk("t6_in_ready", o_ready, 0);   chk("t6_out_bit", o_bit, 0);
        chk("t6_out_valid", o_valid, 0);  chk("t6_start_nrzi", o_start_nrzi, 0);
        chk("t6_done", o_done, 0);        chk("t6_active", o_active, 0);
        chk("t6_stuff_err", o_stuff_err, 0);
        start_v = 1'b0; valid_v = 1'b0; bit_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_leftover", expq.size(), 0);
        rst_n = 1'b1;
        expq.delete();
        bits = {};
        for (int i = 0; i < 16; i++) bits.push_back(1'b0);
        for (int i = 0; i < 5; i++) bits.push_back(1'b1);
        bits.push_back(1'b0); bits.push_back(1'b1);
        send(1'b0, bits, 1'b0, 1'b0, dc, st, dr);
        chk("t7_stall", st, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bitstuff_codec.md
# bitstuff_codec

Parametrised USB-style bit stuffer/unstuffer on the serial path between the packet serialiser and the NRZI encoder (TX) or between the NRZI decoder and the packet deserialiser (RX). After an unstuffed header region of `BYPASS_BITS` bits, TX inserts a 0 after every run of `RUN_LEN` consecutive 1s and RX removes it. Direction is selected per packet. RX flags a stuff violation when a run of `RUN_LEN` ones is followed by a 1. Bits move over a valid/ready handshake, so TX can back-pressure the source during insertion.

## Interface
- `RUN_LEN`, default 6: ones-run length that triggers stuffing; legal 1..15.
- `BYPASS_BITS`, default 16: leading bits per packet that pass unstuffed (SYNC+PID); legal 0..255.
- `clk  in  1`: clock, rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: begins a packet; sampled only in IDLE.
- `mode  in  1`: 0 = stuff (TX), 1 = unstuff (RX); latched when `start` is accepted.
- `endb  in  1`: end of packet; level, held by source until `done`.
- `in_bit  in  1`: serial data in.
- `in_valid  in  1`: `in_bit` is valid.
- `in_ready  out  1`: block accepts `in_bit` this cycle.
- `out_bit  out  1`: serial data out; 0 whenever `out_valid`=0.
- `out_valid  out  1`: `out_bit` is valid.
- `start_nrzi  out  1`: one-cycle pulse when `start` is accepted.
- `done  out  1`: one-cycle pulse when the packet ends.
- `active  out  1`: high in any state other than IDLE.
- `stuff_err  out  1`: sticky RX violation flag; cleared on the next accepted `start` or on reset.

## Operation
- States: IDLE, BYPASS, RUN, INSERT. INSERT is used only in TX.
- Counters, both cleared on an accepted `start`:
  - `ones`, width $clog2(RUN_LEN+1).
  - `byp`, width max(1, $clog2(BYPASS_BITS+1)).
- Transfer = `in_valid & in_ready`.
- IDLE:
  - `in_ready`=0.
  - On `start`: latch `mode`, pulse `start_nrzi`, clear `stuff_err`/`ones`/`byp`.
  - Next state is BYPASS, or RUN if `BYPASS_BITS`=0.
  - `endb` is ignored in IDLE.
- BYPASS:
  - `in_ready`=1; on a transfer, `out_bit`=`in_bit`, `out_valid`=1, `byp`++.
  - After transfer number `BYPASS_BITS`, go to RUN.
  - `ones` stays 0; header bits never count toward a run.
- RUN, TX:
  - On a transfer, `out_bit`=`in_bit`, `out_valid`=1.
  - If `in_bit`=1, `ones`++; otherwise `ones`=0.
  - If a 1 makes `ones` reach `RUN_LEN`, go to INSERT.
- INSERT (TX):
  - `in_ready`=0, `out_bit`=0, `out_valid`=1, `ones`=0.
  - Always returns to RUN after one cycle.
- RUN, RX:
  - `in_ready`=1.
  - If `ones`<`RUN_LEN`: pass the bit and update `ones` as in TX.
  - If `ones`=`RUN_LEN` and the bit is 0: drop it (`out_valid`=0), `ones`=0.
  - If `ones`=`RUN_LEN` and the bit is 1: set `stuff_err`, pulse `done`, go to IDLE.
- End of packet: `endb`=1 in BYPASS or RUN means `in_ready`=0 that cycle, `done` pulses, and the next state is IDLE.
  - In INSERT, `endb` is deferred: the stuffed 0 is emitted first, and `done` follows in the next cycle.
  - A run that completes on the final data bit therefore still receives its stuffed 0.

## Timing
- Data path is combinational: `out_bit`/`out_valid` follow `in_bit`/`in_valid` in the same cycle (0 latency).
- TX throughput: one output bit per cycle. Each insertion costs one cycle of `in_ready`=0.
- RX throughput: `in_ready`=1 every cycle while active. Each dropped stuff bit gives one cycle of `out_valid`=0.
- `start_nrzi` is asserted in the same cycle `start` is sampled in IDLE. `done` is asserted in the cycle `endb` (or the error) is processed; `active` falls the next cycle.
- `start` while `active`=1 is ignored. `start` and `endb` together in IDLE: `start` is taken.
- Reset, including mid-packet: state = IDLE and counters = 0 immediately.
  - All outputs read 0 during and after reset: `in_ready`, `out_bit`, `out_valid`, `start_nrzi`, `done`, `active`, `stuff_err`.
  - No pending insertion survives reset.

## Test plan
- TX, defaults: 16 header bits of 1s, then 8 ones, then `endb`.
  - Output: 16 ones, 6 ones, 0, 2 ones, then `done`.
  - `in_ready` is low exactly 1 cycle.
- TX, `BYPASS_BITS`=0, `RUN_LEN`=3: 1,1,1 then `endb` asserted in the INSERT cycle.
  - Output: 1,1,1,0, then `done` one cycle later.
- RX, defaults: 16 header bits, then 1×6, 0, 1, 0.
  - `out_valid` is low for the stuffed 0; payload out = 1×6, 1, 0; `stuff_err`=0.
- RX violation: 16 header bits, then 1×7.
  - `stuff_err`=1 and `done` pulse on the 7th one; IDLE next cycle.
  - `stuff_err` is held until the next `start`.
- Back-pressure: TX with `in_valid` toggling 1,0,1,0 over 1×6.
  - Insertion occurs only after the 6th accepted 1; idle cycles do not reset `ones`.
- Reset asserted in INSERT:
  - All outputs 0 asynchronously.
  - After release, a `start` runs a clean packet with no spurious 0.
